// File: rtl/sp_ddr_rd_stream.sv
// DDR read engine: splits a read command into Avalon-MM bursts under FIFO credit
// and re-emits the returned beats as framed Avalon-ST packets.
module sp_ddr_rd_stream #(
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int PKT_BEATS  = 16
) (
  input  logic         i_clk156m,
  input  logic         i_arst_n,
  input  logic         i_ddr_wxr,
  input  logic [3:0]   i_ddr_area,
  input  logic [26:0]  i_ddr_addr,
  input  logic [31:0]  i_ddr_size,
  input  logic         i_ddr_start,
  output logic         o_ddr_endp,
  output logic         o_busy,
  output logic         o_err_size,
  output logic         o_err_ovf,
  output logic         o_avm_read,
  output logic [30:0]  o_avm_address,
  output logic [4:0]   o_avm_burstcount,
  input  logic         i_avm_waitrequest,
  input  logic         i_avm_readdatavalid,
  input  logic [127:0] i_avm_readdata,
  output logic         o_rd_sop,
  output logic         o_rd_eop,
  output logic         o_rd_valid,
  output logic [127:0] o_rd_data,
  input  logic         i_rd_ready,
  output logic         o_rd_first,
  output logic         o_rd_last
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;
  localparam int PW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state;
  logic [3:0]     area;
  logic [26:0]    cmd_addr;
  logic [27:0]    beats;
  logic [27:0]    remaining;
  logic [27:0]    k;
  logic [PW-1:0]  pkt;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  mem_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [127:0]   mem [FIFO_DEPTH];
  logic           out_valid;
  logic [127:0]   out_data;
  logic           avm_read;
  logic [4:0]     burstcount;
  logic           endp;
  logic           err_size;
  logic           err_ovf;

  function automatic logic [4:0] burst_len(input logic [27:0] n);
    return (n >= 28'(BURST_MAX)) ? 5'(BURST_MAX) : n[4:0];
  endfunction

  logic [27:0]   start_beats;
  logic          start_hit;
  logic          size_bad;
  logic [CW-1:0] fifo_count;
  logic          full;
  logic          pop;
  logic          load;
  logic          mem_empty;
  logic          wr_ok;
  logic          bypass;
  logic          mem_wr;
  logic          mem_rd;
  logic          accept;
  logic          last_beat;
  logic [4:0]    cur_len;
  logic [SW-1:0] need;
  logic          credit_ok;

  assign start_beats = i_ddr_size[31:4];
  assign start_hit   = i_ddr_start & ~i_ddr_wxr;
  assign size_bad    = (|i_ddr_size[3:0]) | (start_beats == 28'd0);

  // The output register counts as one FIFO slot so credit covers every stored beat.
  assign fifo_count = mem_cnt + CW'(out_valid);
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign pop        = out_valid & i_rd_ready;
  assign load       = ~out_valid | pop;
  assign mem_empty  = (mem_cnt == '0);
  assign wr_ok      = i_avm_readdatavalid & ~full;
  assign bypass     = wr_ok & load & mem_empty;
  assign mem_wr     = wr_ok & ~bypass;
  assign mem_rd     = load & ~mem_empty;

  assign accept    = avm_read & ~i_avm_waitrequest;
  assign last_beat = (k == beats - 28'd1);
  assign cur_len   = burst_len(remaining);
  assign need      = SW'(fifo_count) + SW'(outstanding) + SW'(cur_len);
  assign credit_ok = (need <= SW'(FIFO_DEPTH));

  always_ff @(posedge i_clk156m) begin
    if (mem_wr) mem[wr_ptr] <= i_avm_readdata;
  end

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= IDLE;
      area        <= '0;
      cmd_addr    <= '0;
      beats       <= '0;
      remaining   <= '0;
      k           <= '0;
      pkt         <= '0;
      outstanding <= '0;
      mem_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      avm_read    <= 1'b0;
      burstcount  <= '0;
      endp        <= 1'b0;
      err_size    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      endp     <= 1'b0;
      err_size <= 1'b0;

      // A beat arriving into a full FIFO is lost but still retires its credit.
      if (i_avm_readdatavalid && full) err_ovf <= 1'b1;
      outstanding <= outstanding + (accept ? CW'(burstcount) : '0)
                     - CW'(i_avm_readdatavalid);
      mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(mem_rd);
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);

      if (load) begin
        if (mem_rd) begin
          out_valid <= 1'b1;
          out_data  <= mem[rd_ptr];
        end else if (bypass) begin
          out_valid <= 1'b1;
          out_data  <= i_avm_readdata;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (pop) begin
        k   <= k + 28'd1;
        pkt <= (pkt == PW'(PKT_BEATS - 1)) ? '0 : pkt + PW'(1);
      end

      case (state)
        IDLE: begin
          if (start_hit) begin
            if (size_bad) begin
              err_size <= 1'b1;
              endp     <= 1'b1;
            end else begin
              area       <= i_ddr_area;
              cmd_addr   <= i_ddr_addr;
              beats      <= start_beats;
              remaining  <= start_beats;
              k          <= '0;
              pkt        <= '0;
              err_ovf    <= 1'b0;
              avm_read   <= 1'b1;
              burstcount <= burst_len(start_beats);
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            avm_read  <= 1'b0;
            cmd_addr  <= cmd_addr + 27'(burstcount);
            remaining <= remaining - 28'(burstcount);
            if (remaining == 28'(burstcount)) state <= DRAIN;
          end else if (!avm_read && credit_ok) begin
            avm_read   <= 1'b1;
            burstcount <= cur_len;
          end
        end
        DRAIN: begin
          // Second term only matters after dropped beats, when the last index never shows.
          if ((pop && last_beat) ||
              (outstanding == '0 && fifo_count == '0 && !i_avm_readdatavalid)) begin
            endp  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ddr_endp       = endp;
  assign o_busy           = (state != IDLE);
  assign o_err_size       = err_size;
  assign o_err_ovf        = err_ovf;
  assign o_avm_read       = avm_read;
  assign o_avm_address    = {area, cmd_addr};
  assign o_avm_burstcount = burstcount;
  assign o_rd_valid       = out_valid;
  assign o_rd_data        = out_data;
  assign o_rd_sop         = out_valid & (pkt == '0);
  assign o_rd_eop         = out_valid & ((pkt == PW'(PKT_BEATS - 1)) | last_beat);
  assign o_rd_first       = out_valid & (k == 28'd0);
  assign o_rd_last        = out_valid & last_beat;

endmodule
